// File: rtl/aircraft_agent_if.sv
// aircraft_agent_if: command, UART and status signals between an aircraft agent and its environment
interface aircraft_agent_if;
  logic cmd_valid;
  logic cmd_land;
  logic cmd_ready;
  logic [8:0] uart_tx_data;
  logic uart_tx_send;
  logic uart_tx_ready;
  logic [8:0] uart_rx_data;
  logic uart_rx_valid;
  logic cleared;
  logic diverted;
  logic fail;
  logic on_runway;
  logic runway_id;
  modport master (
    output cmd_valid, cmd_land, uart_tx_ready, uart_rx_data, uart_rx_valid,
    input cmd_ready, uart_tx_data, uart_tx_send, cleared, diverted, fail, on_runway, runway_id
  );
  modport slave (
    input cmd_valid, cmd_land, uart_tx_ready, uart_rx_data, uart_rx_valid,
    output cmd_ready, uart_tx_data, uart_tx_send, cleared, diverted, fail, on_runway, runway_id
  );
endinterface

// File: rtl/aircraft_agent.sv
// aircraft_agent: aircraft-side BobATC endpoint that requests the runway, tracks tower replies and declares once clear of it
module aircraft_agent #(
  parameter logic [3:0] PLANE_ID = 4'd0,
  parameter int RUNWAY_CYCLES = 16,
  parameter int REPLY_TIMEOUT = 256,
  parameter int RETRY_LIMIT = 3
) (
  input logic clock,
  input logic reset,
  aircraft_agent_if.slave bus
);
  localparam int TW = $clog2(REPLY_TIMEOUT);
  localparam int OW = $clog2(RUNWAY_CYCLES + 1);
  localparam logic [2:0] T_REQUEST = 3'b000;
  localparam logic [2:0] T_DECLARE = 3'b001;
  localparam logic [2:0] T_CLEAR = 3'b100;
  localparam logic [2:0] T_HOLD = 3'b101;
  localparam logic [2:0] T_SAY_AGAIN = 3'b110;
  localparam logic [2:0] T_DIVERT = 3'b111;
  typedef enum logic [2:0] {IDLE, TX_REQ, WAIT_ACK, HOLDING, ON_RUNWAY, TX_DECL} state_t;
  state_t state, state_n;
  logic land, runway, cleared_q, diverted_q, fail_q;
  logic [3:0] retries;
  logic [TW-1:0] timer;
  logic [OW-1:0] occ;
  logic [8:0] tx_data, req_word;
  logic match, hold, clear, divert, again, timeout;
  logic load_req, load_decl, take_clear, take_divert, give_up, bump;
  logic unused_rx;
  assign match = bus.uart_rx_valid && bus.uart_rx_data[8:5] == PLANE_ID;
  assign hold = match && bus.uart_rx_data[4:2] == T_HOLD;
  assign clear = match && bus.uart_rx_data[4:2] == T_CLEAR;
  assign divert = match && bus.uart_rx_data[4:2] == T_DIVERT;
  assign again = match && bus.uart_rx_data[4:2] == T_SAY_AGAIN;
  assign unused_rx = bus.uart_rx_data[1];
  // retry on the edge where the timer would reach REPLY_TIMEOUT-1, so the resend lands REPLY_TIMEOUT cycles after the last send
  assign timeout = timer == TW'(REPLY_TIMEOUT - 2);
  assign req_word = {PLANE_ID, T_REQUEST, state == IDLE ? bus.cmd_land : land, 1'b0};
  assign bus.cmd_ready = state == IDLE;
  assign bus.uart_tx_send = (state == TX_REQ || state == TX_DECL) && bus.uart_tx_ready;
  assign bus.uart_tx_data = tx_data;
  assign bus.cleared = cleared_q;
  assign bus.diverted = diverted_q;
  assign bus.fail = fail_q;
  assign bus.on_runway = state == ON_RUNWAY;
  assign bus.runway_id = runway;
  always_comb begin
    state_n = state;
    load_req = 1'b0;
    load_decl = 1'b0;
    take_clear = 1'b0;
    take_divert = 1'b0;
    give_up = 1'b0;
    bump = 1'b0;
    case (state)
      IDLE: if (bus.cmd_valid) begin
        state_n = TX_REQ;
        load_req = 1'b1;
      end
      TX_REQ: if (bus.uart_tx_ready) state_n = WAIT_ACK;
      WAIT_ACK, HOLDING: begin
        take_clear = clear;
        take_divert = divert;
        if (clear) state_n = ON_RUNWAY;
        else if (divert) state_n = IDLE;
        else if (state == WAIT_ACK && hold) state_n = HOLDING;
        else if (state == WAIT_ACK && (again || timeout)) begin
          give_up = retries == 4'(RETRY_LIMIT);
          bump = !give_up;
          load_req = !give_up;
          state_n = give_up ? IDLE : TX_REQ;
        end
      end
      ON_RUNWAY: if (occ == OW'(RUNWAY_CYCLES - 1)) begin
        state_n = TX_DECL;
        load_decl = 1'b1;
      end
      TX_DECL: if (bus.uart_tx_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      land <= 1'b0;
      runway <= 1'b0;
      retries <= '0;
      timer <= '0;
      occ <= '0;
      tx_data <= '0;
      cleared_q <= 1'b0;
      diverted_q <= 1'b0;
      fail_q <= 1'b0;
    end else begin
      state <= state_n;
      timer <= state == WAIT_ACK ? timer + 1'b1 : '0;
      occ <= state == ON_RUNWAY ? occ + 1'b1 : '0;
      retries <= state == IDLE ? '0 : retries + 4'(bump);
      cleared_q <= take_clear;
      diverted_q <= take_divert;
      fail_q <= give_up;
      if (state == IDLE && bus.cmd_valid) land <= bus.cmd_land;
      if (take_clear) runway <= bus.uart_rx_data[0];
      tx_data <= load_req ? req_word : load_decl ? {PLANE_ID, T_DECLARE, 1'b0, runway} : tx_data;
    end
  end
endmodule

// File: tb/tb_aircraft_agent.sv
// tb_aircraft_agent: directed test-plan scenarios plus random traffic against a cycle-level protocol model
module tb_aircraft_agent;
  localparam logic [3:0] ID = 4'd5;
  localparam int RC = 16;
  localparam int RT = 256;
  localparam int RL = 3;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int n_chk = 0;
  int n_err = 0;
  bit run = 1'b0;
  aircraft_agent_if bus();
  aircraft_agent #(.PLANE_ID(ID), .RUNWAY_CYCLES(RC), .REPLY_TIMEOUT(RT), .RETRY_LIMIT(RL)) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endfunction

  // Reference model: phase 0 idle, 1 sending request, 2 awaiting reply, 3 holding, 4 on runway, 5 sending declare
  int m_ph, m_sends, m_left, m_deadline;
  logic [8:0] m_word;
  logic m_rwy, m_clr, m_div, m_fl, hit;
  logic [2:0] ty;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_ph = 0; m_sends = 0; m_left = 0; m_deadline = 0;
      m_word = '0; m_rwy = 0; m_clr = 0; m_div = 0; m_fl = 0;
    end else begin
      hit = bus.uart_rx_valid && bus.uart_rx_data[8:5] == ID;
      ty = hit ? bus.uart_rx_data[4:2] : 3'b000;
      m_clr = 0; m_div = 0; m_fl = 0;
      case (m_ph)
        0: if (bus.cmd_valid) begin
          m_word = {ID, 3'b000, bus.cmd_land, 1'b0};
          m_sends = 0;
          m_ph = 1;
        end
        1: if (bus.uart_tx_ready) begin
          m_sends++;
          m_deadline = cyc + RT;
          m_ph = 2;
        end
        2, 3: begin
          if (ty == 3'b100) begin
            m_rwy = bus.uart_rx_data[0]; m_left = RC; m_clr = 1; m_ph = 4;
          end else if (ty == 3'b111) begin
            m_div = 1; m_ph = 0;
          end else if (m_ph == 2 && ty == 3'b101) m_ph = 3;
          else if (m_ph == 2 && (ty == 3'b110 || cyc + 1 == m_deadline)) begin
            if (m_sends > RL) begin m_fl = 1; m_ph = 0; end
            else m_ph = 1;
          end
        end
        4: begin
          m_left--;
          if (m_left == 0) begin m_word = {ID, 3'b001, 1'b0, m_rwy}; m_ph = 5; end
        end
        default: if (bus.uart_tx_ready) m_ph = 0;
      endcase
    end
  end

  always @(negedge clock) if (run) begin
    chk("cmd_ready", bus.cmd_ready, m_ph == 0);
    chk("tx_send", bus.uart_tx_send, (m_ph == 1 || m_ph == 5) && bus.uart_tx_ready);
    chk("tx_data", bus.uart_tx_data, m_word);
    chk("cleared", bus.cleared, m_clr);
    chk("diverted", bus.diverted, m_div);
    chk("fail", bus.fail, m_fl);
    chk("on_runway", bus.on_runway, m_ph == 4);
    chk("runway_id", bus.runway_id, m_rwy);
  end

  logic [8:0] sent_w[$];
  int sent_c[$];
  int n_clr, n_div, n_flp, n_ron;
  always @(negedge clock) begin
    if (bus.uart_tx_send === 1'b1) begin sent_w.push_back(bus.uart_tx_data); sent_c.push_back(cyc); end
    n_clr += int'(bus.cleared === 1'b1);
    n_div += int'(bus.diverted === 1'b1);
    n_flp += int'(bus.fail === 1'b1);
    n_ron += int'(bus.on_runway === 1'b1);
  end

  function automatic logic [8:0] sw(input int i);
    return i < sent_w.size() ? sent_w[i] : 9'h1FF;
  endfunction
  task automatic clear_log();
    sent_w.delete(); sent_c.delete();
    n_clr = 0; n_div = 0; n_flp = 0; n_ron = 0;
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic cmd(input logic l);
    bus.cmd_valid = 1'b1; bus.cmd_land = l;
    tick(1);
    bus.cmd_valid = 1'b0;
  endtask
  task automatic rx(input logic [8:0] w);
    bus.uart_rx_data = w; bus.uart_rx_valid = 1'b1;
    tick(1);
    bus.uart_rx_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] w;
    int answered;
    bus.cmd_valid = 0; bus.cmd_land = 0; bus.uart_tx_ready = 1;
    bus.uart_rx_data = '0; bus.uart_rx_valid = 0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    run = 1'b1;
    chk("reset_ready", bus.cmd_ready, 1);
    chk("reset_data", bus.uart_tx_data, 0);
    chk("reset_runway", bus.on_runway, 0);
    // takeoff with hold then clear on runway 1
    clear_log(); cmd(0); tick(3); rx(9'h0B4); tick(3); rx(9'h0B1); tick(25);
    chk("t1_req", sw(0), 9'h0A0);
    chk("t1_decl", sw(1), 9'h0A5);
    chk("t1_nsend", sent_w.size(), 2);
    chk("t1_cleared", n_clr, 1);
    chk("t1_rwy", bus.runway_id, 1);
    chk("t1_occupancy", n_ron, 16);
    chk("t1_ready", bus.cmd_ready, 1);
    // landing, other plane's clear ignored
    clear_log(); cmd(1); tick(3); rx(9'h0B4); tick(2); rx(9'h071); tick(3);
    chk("t2_filter_runway", bus.on_runway, 0);
    chk("t2_filter_clr", n_clr, 0);
    rx(9'h0B0); tick(25);
    chk("t2_req", sw(0), 9'h0A2);
    chk("t2_decl", sw(1), 9'h0A4);
    chk("t2_rwy", bus.runway_id, 0);
    chk("t2_occupancy", n_ron, 16);
    // say-again until retries run out
    clear_log(); cmd(0); answered = 0;
    for (int i = 0; i < 100 && n_flp == 0; i++)
      if (sent_w.size() > answered) begin answered++; rx(9'h0B8); end
      else tick(1);
    tick(3);
    chk("t3_nsend", sent_w.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_word", sw(i), 9'h0A0);
    chk("t3_fail", n_flp, 1);
    chk("t3_ready", bus.cmd_ready, 1);
    // silent tower: resend after the timeout, then divert
    clear_log(); cmd(0);
    for (int i = 0; i < 300 && sent_w.size() < 2; i++) tick(1);
    tick(5); rx(9'h0BC); tick(20);
    chk("t4_nsend", sent_w.size(), 2);
    chk("t4_resend", sw(1), 9'h0A0);
    chk("t4_gap", sent_c.size() > 1 ? sent_c[1] - sent_c[0] : 0, RT);
    chk("t4_div", n_div, 1);
    chk("t4_ready", bus.cmd_ready, 1);
    // clear arriving in the timeout cycle beats the retry
    clear_log(); cmd(0);
    for (int i = 0; i < 10 && sent_w.size() < 1; i++) tick(1);
    if (sent_w.size() > 0) while (cyc < sent_c[0] + RT - 1) tick(1);
    rx(9'h0B1); tick(25);
    chk("t4b_nsend", sent_w.size(), 2);
    chk("t4b_decl", sw(1), 9'h0A5);
    chk("t4b_clr", n_clr, 1);
    // backpressure
    clear_log(); bus.uart_tx_ready = 0; cmd(0);
    for (int i = 0; i < 10; i++) begin
      chk("t5_nosend", bus.uart_tx_send, 0);
      chk("t5_data", bus.uart_tx_data, 9'h0A2 ^ 9'h002);
      tick(1);
    end
    bus.uart_tx_ready = 1; tick(3);
    chk("t5_nsend", sent_w.size(), 1);
    rx(9'h0BC); tick(3);
    // reset during runway occupancy
    clear_log(); cmd(0); tick(3); rx(9'h0B1); tick(4);
    #3 reset = 1'b1;
    #1 chk("t6_runway_async", bus.on_runway, 0);
    chk("t6_send_async", bus.uart_tx_send, 0);
    @(posedge clock); #1 reset = 1'b0;
    chk("t6_ready", bus.cmd_ready, 1);
    tick(30);
    chk("t6_nsend", sent_w.size(), 1);
    chk("t6_no_decl", sw(1) == 9'h0A5 || sw(0) == 9'h0A5, 0);
    // random traffic, dense then sparse replies so timeouts also occur
    for (int i = 0; i < 5000; i++) begin
      bus.cmd_valid = $urandom_range(0, 4) == 0;
      bus.cmd_land = 1'($urandom_range(0, 1));
      bus.uart_tx_ready = $urandom_range(0, 9) < 7;
      bus.uart_rx_valid = i < 2000 ? $urandom_range(0, 9) == 0 : $urandom_range(0, 99) == 0;
      w = 9'($urandom);
      w[8:5] = $urandom_range(0, 1) == 1 ? ID : 4'($urandom_range(0, 15));
      bus.uart_rx_data = w;
      reset = $urandom_range(0, 799) == 0;
      tick(1);
    end
    reset = 0; bus.cmd_valid = 0; bus.uart_rx_valid = 0;
    tick(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/aircraft_agent.md
# aircraft_agent

Aircraft-side endpoint of the BobATC 9-bit message protocol: issues takeoff/landing requests to the tower controller over a UART byte interface and interprets tower replies (HOLD, CLEAR, SAY_AGAIN, DIVERT). Once cleared, it models runway occupancy and sends the DECLARE that frees the runway. One instance per simulated plane, used in system benches and multi-plane traffic models facing the tower.

## Interface

- PLANE_ID, 4'd0, this aircraft's ID; placed in every transmitted message and used to filter received ones.
- RUNWAY_CYCLES, 16, cycles spent on the runway after CLEAR, ≥1.
- REPLY_TIMEOUT, 256, cycles to wait for the first reply before retransmitting, ≥2.
- RETRY_LIMIT, 3, retransmissions allowed before giving up, 0..15.

- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  local request to start an operation; accepted only when cmd_ready=1.
- cmd_land  in  1  sampled with cmd_valid: 0 = takeoff, 1 = landing.
- cmd_ready  out  1  high exactly in IDLE.
- uart_tx_data  out  9  outgoing message {plane_id[3:0], msg_type[2:0], msg_action[1:0]}.
- uart_tx_send  out  1  one-cycle transmit strobe.
- uart_tx_ready  in  1  UART transmitter can accept a message.
- uart_rx_data  in  9  incoming message, same format.
- uart_rx_valid  in  1  one-cycle pulse per received message.
- cleared  out  1  one-cycle pulse on accepted CLEAR.
- diverted  out  1  one-cycle pulse on accepted DIVERT.
- fail  out  1  one-cycle pulse when retries are exhausted.
- on_runway  out  1  high while occupying the runway.
- runway_id  out  1  runway granted by the last CLEAR.

## Operation

- Message types: T_REQUEST=000, T_DECLARE=001, T_EMERGENCY=010, T_POSITION=011, T_CLEAR=100, T_HOLD=101, T_SAY_AGAIN=110, T_DIVERT=111.
- Request action: takeoff 2'b00, landing 2'b10.
- CLEAR and DECLARE action: {1'b0, runway}.
- A received message is "matching" when uart_rx_valid=1 and uart_rx_data[8:5]==PLANE_ID.
  - Non-matching messages are ignored in every state.
  - Matching messages are ignored in IDLE, TX_REQ, ON_RUNWAY and TX_DECL.
- States:
  - IDLE: cmd_ready=1. On cmd_valid: latch cmd_land, clear the retry counter, load the request into uart_tx_data, go to TX_REQ.
  - TX_REQ: uart_tx_send = uart_tx_ready. In the first cycle with uart_tx_ready=1, the message is sent; go to WAIT_ACK and clear the timer.
  - WAIT_ACK: the timer increments each cycle.
    - HOLD → HOLDING.
    - CLEAR → ON_RUNWAY; latch runway_id = rx[0].
    - DIVERT → IDLE; pulse diverted.
    - SAY_AGAIN, or the timer reaching REPLY_TIMEOUT-1 → retry.
    - Any other type is ignored.
  - Retry: if retries==RETRY_LIMIT, pulse fail and go to IDLE. Otherwise retries++, reload the request, go to TX_REQ.
  - HOLDING: no timeout.
    - CLEAR → ON_RUNWAY; latch runway_id.
    - DIVERT → IDLE; pulse diverted.
    - All other types are ignored.
  - ON_RUNWAY: on_runway=1. The occupancy counter counts RUNWAY_CYCLES cycles, then load DECLARE {PLANE_ID, 001, {1'b0, runway_id}} and go to TX_DECL.
  - TX_DECL: same handshake as TX_REQ; after the send, go to IDLE.
- The retry counter is 4 bits. The timer is $clog2(REPLY_TIMEOUT) bits and never wraps, because it is cleared on every state entry.
- The block never issues T_EMERGENCY or T_POSITION.

## Timing

- Reset values:
  - uart_tx_data=0, uart_tx_send=0, cleared=0, diverted=0, fail=0, on_runway=0, runway_id=0.
  - cmd_ready=1 (state=IDLE). All counters are 0.
- Reset mid-operation aborts immediately. No DECLARE is sent, and any pending strobe drops asynchronously.
- Output timing:
  - uart_tx_data is registered and stable from the TX-state entry cycle until the send cycle inclusive.
  - uart_tx_send is combinational from state and uart_tx_ready, and is high for exactly one cycle per message.
  - cleared, diverted and fail are registered. Each is high in the cycle after the accepting edge.
  - cleared coincides with the first on_runway cycle.
  - on_runway is high for exactly RUNWAY_CYCLES consecutive cycles.
- Latencies:
  - cmd_valid at edge N → TX_REQ at N+1. The earliest uart_tx_send is cycle N+1.
  - Last on_runway cycle → the DECLARE send is possible in the next cycle.
- With no reply, the retransmit strobe occurs REPLY_TIMEOUT cycles after the previous send, provided uart_tx_ready=1.
- Simultaneous events in WAIT_ACK: a matching reply and the timeout expiring in the same cycle → the reply wins.
- cmd_valid outside IDLE is ignored, not queued.

## Test plan

- Takeoff, PLANE_ID=5, tx_ready=1:
  - cmd_valid with cmd_land=0 → tx 0x0A0.
  - rx 0x0B4 (HOLD), then rx 0x0B1 (CLEAR, runway 1) → cleared pulse, runway_id=1, on_runway for 16 cycles.
  - Then tx 0x0A5 (DECLARE) and cmd_ready=1.
- Landing with filtering: cmd_land=1 → tx 0x0A2.
  - In HOLDING, rx 0x071 (plane 3 CLEAR) → no change.
  - rx 0x0B0 → on_runway, runway_id=0, then tx 0x0A4.
- SAY_AGAIN exhaustion, RETRY_LIMIT=3: answer every request with rx 0x0B8 → exactly 4 sends of 0x0A0, then a fail pulse and IDLE.
- Timeout: no reply after 0x0A0 → resend of 0x0A0 exactly 256 cycles after the first send. rx 0x0BC → diverted pulse, IDLE, no DECLARE.
- Backpressure: hold tx_ready=0 for 10 cycles in TX_REQ → uart_tx_send=0 and uart_tx_data stable throughout. Raise ready → a single strobe.
- Reset mid-ON_RUNWAY: assert reset at cycle 5 of occupancy → on_runway=0 immediately, cmd_ready=1 after release, and no 0x0A5 is transmitted.
